// File: rtl/forward_mul_share_arbiter.sv
// forward_mul_share_arbiter: round-robin sharing of one pipelined unsigned multiplier among NUM_REQ requesters
module forward_mul_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 50,
    parameter int DIN1_WIDTH = 50,
    parameter int DOUT_WIDTH = 99,
    parameter int LATENCY    = 2,
    parameter int ID_WIDTH   = 2
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
    output logic [ID_WIDTH-1:0]              rsp_id
);
    localparam int PW = (DIN0_WIDTH + DIN1_WIDTH > DOUT_WIDTH) ? DIN0_WIDTH + DIN1_WIDTH : DOUT_WIDTH;
    logic [LATENCY-1:0]    vld;
    logic [DOUT_WIDTH-1:0] dat [LATENCY];
    logic [ID_WIDTH-1:0]   tag [LATENCY];
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   win;
    logic                  found;
    logic                  advance;
    logic                  go;
    logic [DIN0_WIDTH-1:0] a;
    logic [DIN1_WIDTH-1:0] b;
    logic [PW-1:0]         full;
    int                    cand;
    assign advance   = !vld[LATENCY-1] || rsp_ready;
    assign go        = found && advance && ap_rst_n;
    assign req_ready = go ? NUM_REQ'(1) << win : '0;
    assign a         = req_din0[win*DIN0_WIDTH +: DIN0_WIDTH];
    assign b         = req_din1[win*DIN1_WIDTH +: DIN1_WIDTH];
    assign full      = PW'(a) * PW'(b);
    assign rsp_valid = vld[LATENCY-1];
    assign rsp_dout  = dat[LATENCY-1];
    assign rsp_id    = tag[LATENCY-1];
    // round-robin search starting one past the last granted requester
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_valid[ID_WIDTH'(cand)]) begin
                found = 1'b1;
                win   = ID_WIDTH'(cand);
            end
        end
    end
    // product pipeline; every stage moves together only when the output can drain
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld        <= '0;
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
            for (int i = 0; i < LATENCY; i++) begin
                dat[i] <= '0;
                tag[i] <= '0;
            end
        end else if (advance) begin
            vld[0] <= go;
            dat[0] <= full[DOUT_WIDTH-1:0];
            tag[0] <= win;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
                tag[i] <= tag[i-1];
            end
            if (go) last_grant <= win;
        end
    end
endmodule
